// File: rtl/core_pkg.sv
// Shared types for the hazard controller: forwarding-select codes and FSM states.
package core_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazard_state_e;

  // The Memory-stage producer beats the Writeback producer. x0 is never forwarded.
  function automatic fwd_sel_e fwd_sel(input logic [4:0] rs,
                                       input logic [4:0] rd_m, input logic wr_m,
                                       input logic [4:0] rd_w, input logic wr_w);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) return FWD_M;
    if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline is master, hazard_unit is slave.
interface hazard_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [4:0]            Rs1D, Rs2D;
  logic [4:0]            Rs1E, Rs2E, RdE;
  logic [4:0]            RdM, RdW;
  logic                  RegWriteM, RegWriteW;
  logic                  ResultSrcE0;
  logic                  PCSrcE;
  logic                  MemReqM, MemReadyM;
  logic [1:0]            ForwardAE, ForwardBE;
  logic                  StallF, StallD, StallE, StallM;
  logic                  FlushD, FlushE, FlushW;
  logic [DATA_WIDTH-1:0] StallCount, FlushCount;
  logic                  MemErr;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, StallCount, FlushCount, MemErr
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, StallCount, FlushCount, MemErr
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  // Count up on inc_i until every bit is set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller: operand-forward selects, load-use / branch / memory-wait
// stall and flush controls, memory-timeout flag and saturating perf counters.
module hazard_unit
  import core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input logic          clk,
  input logic          rst_n,
  hazard_unit_if.slave hz
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_TIMEOUT);

  hazard_state_e     state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic              lw_stall;
  logic              stall_f, stall_d, stall_e, stall_m;
  logic              flush_d, flush_e, flush_w;

  // Forwarding selects are independent of the FSM.
  always_comb begin
    hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
    hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
  end

  assign lw_stall = hz.ResultSrcE0 && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  // Next-state and stage controls; memory miss outranks branch, branch outranks load-use.
  always_comb begin
    state_d = state_q;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.MemReqM && !hz.MemReadyM) begin
          {stall_f, stall_d, stall_e, stall_m, flush_w} = '1;
          state_d = MEM_WAIT;
        end else if (hz.PCSrcE) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (lw_stall) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (hz.MemReadyM) begin
          state_d = RUN;
        end else begin
          {stall_f, stall_d, stall_e, stall_m, flush_w} = '1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Wait counter is held at zero in RUN (so it is clear on entry) and saturates at the limit.
  always_comb begin
    wait_d = wait_q;
    err_d  = err_q;
    if (state_q == RUN) begin
      wait_d = '0;
    end else begin
      if (wait_q != WAIT_LIM) wait_d = wait_q + 1'b1;
      if (wait_d == WAIT_LIM) err_d = 1'b1;
    end
  end

  // State, wait counter and sticky error register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(.WIDTH(DATA_WIDTH)) u_stall_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (stall_f),
    .count_o(hz.StallCount)
  );

  sat_counter #(.WIDTH(DATA_WIDTH)) u_flush_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (flush_d || flush_e),
    .count_o(hz.FlushCount)
  );

  always_comb begin
    hz.StallF = stall_f;
    hz.StallD = stall_d;
    hz.StallE = stall_e;
    hz.StallM = stall_m;
    hz.FlushD = flush_d;
    hz.FlushE = flush_e;
    hz.FlushW = flush_w;
    hz.MemErr = err_q;
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (MEM_TIMEOUT=4) plus a narrow sat_counter for saturation.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_unit_if #(.DATA_WIDTH(32)) hif ();

  hazard_unit #(.DATA_WIDTH(32), .MEM_TIMEOUT(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hif.slave)
  );

  logic       sc_inc;
  logic [2:0] sc_cnt;

  sat_counter #(.WIDTH(3)) u_sc (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (sc_inc),
    .count_o(sc_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Controls packed as {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}.
  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    chk(tag, {25'd0, hif.StallF, hif.StallD, hif.StallE, hif.StallM,
              hif.FlushD, hif.FlushE, hif.FlushW}, {25'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hif.Rs1D = '0; hif.Rs2D = '0; hif.Rs1E = '0; hif.Rs2E = '0; hif.RdE = '0;
    hif.RdM = '0; hif.RdW = '0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
    hif.ResultSrcE0 = 1'b0; hif.PCSrcE = 1'b0; hif.MemReqM = 1'b0; hif.MemReadyM = 1'b0;
  endtask

  initial begin
    clear_inputs();
    sc_inc = 1'b0;
    rst_n  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_stallcnt", hif.StallCount, 32'd0);
    chk("rst_flushcnt", hif.FlushCount, 32'd0);
    chk("rst_memerr", {31'd0, hif.MemErr}, 32'd0);
    chk_ctl("rst_ctl", 7'b0000000);

    // Forwarding
    hif.RdM = 5'd5; hif.RegWriteM = 1'b1; hif.RdW = 5'd5; hif.RegWriteW = 1'b1;
    hif.Rs1E = 5'd5; hif.Rs2E = 5'd5;
    #1;
    chk("fwdA_M_beats_W", {30'd0, hif.ForwardAE}, 32'd2);
    chk("fwdB_M_beats_W", {30'd0, hif.ForwardBE}, 32'd2);
    hif.RegWriteM = 1'b0;
    #1;
    chk("fwdA_W", {30'd0, hif.ForwardAE}, 32'd1);
    hif.RegWriteM = 1'b1; hif.RdM = 5'd0; hif.RdW = 5'd0; hif.Rs1E = 5'd0;
    #1;
    chk("fwdA_x0", {30'd0, hif.ForwardAE}, 32'd0);
    hif.RdW = 5'd9; hif.Rs2E = 5'd9; hif.RdM = 5'd3; hif.Rs1E = 5'd4;
    #1;
    chk("fwdB_W_only", {30'd0, hif.ForwardBE}, 32'd1);
    chk("fwdA_nomatch", {30'd0, hif.ForwardAE}, 32'd0);
    clear_inputs();

    // Load-use
    hif.ResultSrcE0 = 1'b1; hif.RdE = 5'd7; hif.Rs2D = 5'd7; hif.Rs1D = 5'd2;
    #1;
    chk_ctl("lw_ctl", 7'b1100010);
    tick();
    chk("lw_stallcnt", hif.StallCount, 32'd1);
    chk("lw_flushcnt", hif.FlushCount, 32'd1);

    // Load-use squashed by taken branch
    hif.PCSrcE = 1'b1;
    #1;
    chk_ctl("br_lw_ctl", 7'b0000110);
    tick();
    chk("br_stallcnt", hif.StallCount, 32'd1);
    chk("br_flushcnt", hif.FlushCount, 32'd2);
    clear_inputs();

    // Load into x0 never stalls
    hif.ResultSrcE0 = 1'b1; hif.RdE = 5'd0; hif.Rs1D = 5'd0;
    #1;
    chk_ctl("lw_x0_ctl", 7'b0000000);
    clear_inputs();

    // Memory miss: 3 stall cycles, branch ignored while waiting
    hif.MemReqM = 1'b1; hif.MemReadyM = 1'b0;
    #1;
    chk_ctl("miss_n0_ctl", 7'b1111001);
    tick();
    hif.PCSrcE = 1'b1;
    #1;
    chk_ctl("miss_n1_ctl", 7'b1111001);
    tick();
    chk_ctl("miss_n2_ctl", 7'b1111001);
    tick();
    hif.MemReadyM = 1'b1;
    #1;
    chk_ctl("miss_ready_ctl", 7'b0000000);
    tick();
    clear_inputs();
    #1;
    chk_ctl("miss_run_after", 7'b0000000);
    chk("miss_stallcnt", hif.StallCount, 32'd4);
    chk("miss_flushcnt", hif.FlushCount, 32'd2);
    chk("miss_no_err", {31'd0, hif.MemErr}, 32'd0);

    // Ready in the request cycle: no stall, no state change
    hif.MemReqM = 1'b1; hif.MemReadyM = 1'b1;
    #1;
    chk_ctl("hit_ctl", 7'b0000000);
    tick();
    clear_inputs();
    #1;
    chk_ctl("hit_still_run", 7'b0000000);

    // Timeout: ready withheld 6 cycles
    hif.MemReqM = 1'b1; hif.MemReadyM = 1'b0;
    tick();
    for (int i = 1; i <= 5; i++) begin
      if (i == 4) chk("to_err_before", {31'd0, hif.MemErr}, 32'd0);
      if (i == 5) chk("to_err_after", {31'd0, hif.MemErr}, 32'd1);
      tick();
    end
    hif.MemReadyM = 1'b1;
    #1;
    chk_ctl("to_exit_ctl", 7'b0000000);
    tick();
    clear_inputs();
    #1;
    chk_ctl("to_run_after", 7'b0000000);
    chk("to_err_sticky", {31'd0, hif.MemErr}, 32'd1);
    chk("to_stallcnt", hif.StallCount, 32'd10);

    // Reset during MEM_WAIT
    hif.MemReqM = 1'b1; hif.MemReadyM = 1'b0;
    tick();
    tick();
    chk_ctl("pre_rst_wait", 7'b1111001);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_inputs();
    #1;
    chk_ctl("rst_wait_ctl", 7'b0000000);
    chk("rst_wait_stallcnt", hif.StallCount, 32'd0);
    chk("rst_wait_flushcnt", hif.FlushCount, 32'd0);
    chk("rst_wait_memerr", {31'd0, hif.MemErr}, 32'd0);

    // Counter saturation on a 3-bit instance
    sc_inc = 1'b1;
    repeat (6) tick();
    chk("sat_6", {29'd0, sc_cnt}, 32'd6);
    repeat (3) tick();
    chk("sat_hold", {29'd0, sc_cnt}, 32'd7);
    sc_inc = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
